// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_packer_if
//  Purpose  : FIFO-pop and packet valid/ready bundle for fifo_rd_packer.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_rd_packer_if #(
    parameter int WD = 4,
    parameter int NW = 4,
    parameter int CW = $clog2(NW) + 1
);
    logic          empty;
    logic          rd_en;
    logic [WD-1:0] rdata;
    logic          rdata_valid;
    logic          flush;
    logic [NW*WD-1:0] out_data;
    logic [CW-1:0] out_cnt;
    logic          out_valid;
    logic          out_ready;
    logic          ovf_err;

    // master is the packer itself, slave is the FIFO plus packet consumer
    modport master (
        input  empty, rdata, rdata_valid, flush, out_ready,
        output rd_en, out_data, out_cnt, out_valid, ovf_err
    );
    modport slave (
        output empty, rdata, rdata_valid, flush, out_ready,
        input  rd_en, out_data, out_cnt, out_valid, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_packer
//  Purpose  : Pops WD-bit FIFO words and packs NW of them per output packet;
//             a flush pulse emits whatever partial packet has been gathered.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
    parameter int WD = 4,
    parameter int NW = 4
) (
    input  logic              rclk,
    input  logic              rst_n,
    fifo_rd_packer_if.master  bus
);
    localparam int CW = $clog2(NW) + 1;
    localparam logic [CW-1:0] c_nw     = CW'(NW);
    localparam logic [0:0]    c_s_fill = 1'b0;
    localparam logic [0:0]    c_s_hold = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CW-1:0]    r_fill;
    logic [CW-1:0]    r_inflight;
    logic             r_flush_pend;
    logic             r_ovf_err;
    logic [NW*WD-1:0] r_out_data;
    logic [CW-1:0]    r_out_cnt;

    logic             w_rd_en;
    logic             w_cap;
    logic [CW-1:0]    w_fill_inc;
    logic             w_full;
    logic             w_resolve;
    logic             w_handshake;

    assign w_cap       = bus.rdata_valid && (r_inflight != '0);
    assign w_fill_inc  = r_fill + CW'(w_cap);
    assign w_full      = (r_state == c_s_fill) && w_cap && (w_fill_inc == c_nw);
    // A pending flush is only resolved once the last popped word has landed
    assign w_resolve   = (r_state == c_s_fill) && r_flush_pend && (r_inflight == '0);
    assign w_handshake = (r_state == c_s_hold) && bus.out_ready;

    // State register
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_s_fill;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_fill: begin
                if (w_full || (w_resolve && (r_fill != '0))) begin
                    w_state_nxt = c_s_hold;
                end
            end
            c_s_hold: begin
                if (bus.out_ready) begin
                    w_state_nxt = c_s_fill;
                end
            end
            default: w_state_nxt = c_s_fill;
        endcase
    end

    // Output logic; outstanding pops are counted so the packet never overfills
    always_comb begin
        w_rd_en = rst_n && (r_state == c_s_fill) && !bus.empty && !r_flush_pend
                  && ((r_fill + r_inflight) < c_nw);
        bus.rd_en     = w_rd_en;
        bus.out_valid = (r_state == c_s_hold);
    end

    // Datapath: capture, packet count, flush and overflow tracking
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill       <= '0;
            r_inflight   <= '0;
            r_flush_pend <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_out_data   <= '0;
            r_out_cnt    <= '0;
        end else begin
            r_inflight   <= CW'(w_rd_en);
            r_flush_pend <= (r_flush_pend && !w_resolve) || bus.flush;
            if (bus.rdata_valid && (r_inflight == '0)) begin
                r_ovf_err <= 1'b1;
            end
            if (w_handshake) begin
                r_fill     <= '0;
                r_out_data <= '0;
            end else if (w_cap) begin
                r_fill <= w_fill_inc;
                for (int k = 0; k < NW; k++) begin
                    if (r_fill == CW'(k)) begin
                        r_out_data[k*WD +: WD] <= bus.rdata;
                    end
                end
            end
            if (w_full) begin
                r_out_cnt <= c_nw;
            end else if (w_resolve && (r_fill != '0)) begin
                r_out_cnt <= r_fill;
            end
        end
    end

    assign bus.out_data = r_out_data;
    assign bus.out_cnt  = r_out_cnt;
    assign bus.ovf_err  = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_packer
//  Purpose  : Bench for fifo_rd_packer with a queue-based FIFO and packet model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;
    localparam int WD = 4;
    localparam int NW = 4;
    localparam int CW = $clog2(NW) + 1;

    logic rclk  = 1'b0;
    logic rst_n = 1'b0;
    always #5 rclk = ~rclk;

    fifo_rd_packer_if #(.WD(WD), .NW(NW), .CW(CW)) bus ();
    fifo_rd_packer #(.WD(WD), .NW(NW)) dut (.rclk(rclk), .rst_n(rst_n), .bus(bus));

    int n_err = 0;
    int n_chk = 0;

    // FIFO environment
    logic [WD-1:0] fifo_q[$];
    logic          pend_valid;
    logic [WD-1:0] pend_data;
    logic          stim_flush, stim_ready, stim_inject;

    // Packet-level model: list of captured words plus a few flags
    logic [WD-1:0] m_words[$];
    bit            m_inflight, m_fp, m_hold, m_ovf;
    int            m_cnt;

    int               rd_cnt, valid_cycles, pkt_count;
    logic [NW*WD-1:0] last_pkt;
    int               last_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NW*WD-1:0] m_pack();
        logic [NW*WD-1:0] r;
        r = '0;
        for (int k = 0; k < m_words.size(); k++) r[k*WD +: WD] = m_words[k];
        return r;
    endfunction

    task automatic model_reset();
        m_words.delete();
        m_inflight = 0; m_fp = 0; m_hold = 0; m_ovf = 0; m_cnt = 0;
    endtask

    task automatic clr_stats();
        rd_cnt = 0; valid_cycles = 0; pkt_count = 0;
    endtask

    task automatic push(input int a, input int b);
        for (int v = a; v <= b; v++) fifo_q.push_back(WD'(v));
    endtask

    // One clock: drive inputs after negedge, compare, advance model, cross posedge
    task automatic step();
        bit            m_rd, cap, pop;
        logic [WD-1:0] nd;
        bus.empty       = (fifo_q.size() == 0);
        bus.rdata_valid = pend_valid | stim_inject;
        bus.rdata       = pend_valid ? pend_data : '0;
        bus.flush       = stim_flush;
        bus.out_ready   = stim_ready;
        #1;
        m_rd = rst_n && !m_hold && !bus.empty && !m_fp && ((m_words.size() + int'(m_inflight)) < NW);
        chk("rd_en",     bus.rd_en,     m_rd);
        chk("out_valid", bus.out_valid, m_hold);
        chk("out_data",  bus.out_data,  m_pack());
        chk("out_cnt",   bus.out_cnt,   m_cnt);
        chk("ovf_err",   bus.ovf_err,   m_ovf);
        if (bus.rd_en) rd_cnt++;
        if (bus.out_valid) valid_cycles++;
        if (bus.out_valid && bus.out_ready) begin
            pkt_count++;
            last_pkt = bus.out_data;
            last_cnt = int'(bus.out_cnt);
        end
        pop = bus.rd_en && (fifo_q.size() > 0);
        nd  = '0;
        if (pop) nd = fifo_q.pop_front();
        if (!rst_n) begin
            model_reset();
        end else begin
            cap = bus.rdata_valid && m_inflight;
            if (bus.rdata_valid && !m_inflight) m_ovf = 1;
            if (m_hold) begin
                if (bus.out_ready) begin
                    m_hold = 0;
                    m_words.delete();
                end
                m_fp = m_fp | bus.flush;
            end else begin
                if (cap) m_words.push_back(bus.rdata);
                if (m_words.size() == NW) begin
                    m_hold = 1; m_cnt = NW; m_fp = m_fp | bus.flush;
                end else if (m_fp && !m_inflight) begin
                    if (m_words.size() > 0) begin
                        m_hold = 1; m_cnt = m_words.size();
                    end
                    m_fp = bus.flush;
                end else begin
                    m_fp = m_fp | bus.flush;
                end
            end
            m_inflight = m_rd;
        end
        @(negedge rclk);
        pend_valid  = pop;
        pend_data   = nd;
        stim_flush  = 0;
        stim_inject = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.empty = 1'b1; bus.rdata_valid = 1'b0; bus.rdata = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        stim_flush = 0; stim_ready = 0; stim_inject = 0;
        pend_valid = 0; pend_data = '0;
        last_pkt = '0; last_cnt = 0;
        model_reset();
        clr_stats();

        @(negedge rclk);
        step(); step();
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;

        // Full packet, consumer always ready
        push(1, 4); stim_ready = 1; clr_stats();
        repeat (8) step();
        chk("t1_rd_cycles", rd_cnt, 4);
        chk("t1_valid_cycles", valid_cycles, 1);
        chk("t1_pkt", last_pkt, 16'h4321);
        chk("t1_cnt", last_cnt, 4);

        // Back-pressure holds the packet and stops popping
        push(1, 6); stim_ready = 0; clr_stats();
        repeat (14) step();
        chk("t2_rd_cycles", rd_cnt, 4);
        chk("t2_hold_data", bus.out_data, 16'h4321);
        chk("t2_hold_valid", bus.out_valid, 1);
        stim_ready = 1;
        repeat (10) step();
        chk("t2_rd_total", rd_cnt, 6);
        stim_flush = 1; step();
        repeat (5) step();
        chk("t2_tail_pkt", last_pkt, 16'h0065);
        chk("t2_tail_cnt", last_cnt, 2);

        // Partial packet by flush
        push(10, 12);
        repeat (6) step();
        stim_flush = 1; step();
        repeat (5) step();
        chk("t3_pkt", last_pkt, 16'h0CBA);
        chk("t3_cnt", last_cnt, 3);

        // Flush together with the second pop: in-flight word is kept
        push(6, 8); clr_stats();
        step();
        stim_flush = 1; step();
        repeat (3) step();
        chk("t4_rd_cycles", rd_cnt, 2);
        repeat (3) step();
        chk("t4_pkt", last_pkt, 16'h0076);
        chk("t4_cnt", last_cnt, 2);
        repeat (4) step();
        stim_flush = 1; step();
        repeat (5) step();
        chk("t4_tail_pkt", last_pkt, 16'h0008);
        chk("t4_tail_cnt", last_cnt, 1);

        // Flush with nothing gathered is dropped
        clr_stats();
        stim_flush = 1; step();
        repeat (5) step();
        chk("t5_no_valid", valid_cycles, 0);
        push(9, 12);
        repeat (8) step();
        chk("t5_pkt", last_pkt, 16'hCBA9);
        chk("t5_cnt", last_cnt, 4);

        // Stray data strobe, then asynchronous reset mid-packet
        stim_inject = 1; step();
        repeat (3) step();
        chk("t6_ovf_sticky", bus.ovf_err, 1);
        push(1, 2);
        repeat (4) step();
        chk("t6_partial", bus.out_data, 16'h0021);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_data",  bus.out_data,  0);
        chk("t6_rst_cnt",   bus.out_cnt,   0);
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_ovf",   bus.ovf_err,   0);
        chk("t6_rst_rd_en", bus.rd_en,     0);
        model_reset();
        fifo_q.delete();
        pend_valid = 0;
        @(negedge rclk);
        step(); step();
        rst_n = 1'b1;
        step();

        // Randomized traffic
        clr_stats();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) fifo_q.push_back(WD'($urandom));
            stim_ready = ($urandom_range(0, 3) != 0);
            stim_flush = ($urandom_range(0, 15) == 0);
            step();
        end
        stim_ready = 1;
        repeat (20) step();
        stim_flush = 1; step();
        repeat (10) step();
        chk("rand_pkts_seen", (pkt_count > 0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
